// File: rtl/exec_mul_unit.sv
// Pipelined RV32M multiply unit: it reads ready entries from the multiply reservation
// station and broadcasts each tagged result on the CDB after LATENCY stages.
module exec_mul_unit #(
  parameter int unsigned LATENCY    = 3,
  parameter int unsigned DATA_WIDTH = 128
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  flush,
  output logic                  o_rsv_rd_en,
  input  logic [DATA_WIDTH-1:0] issue_data,
  input  logic                  cdb_grant,
  output logic                  cdb_req,
  output logic                  o_cdb_valid,
  output logic [5:0]            o_cdb_tag,
  output logic [31:0]           o_cdb_data,
  output logic                  o_busy
);

  typedef struct packed {
    logic        vld;
    logic [5:0]  tag;
    logic [2:0]  funct3;
    logic [63:0] prod;
  } stage_t;

  stage_t      stg_q [LATENCY];
  stage_t      stg_d [LATENCY];
  stage_t      entry;
  stage_t      tail;
  logic        stall;
  logic [2:0]  in_f3;
  logic [32:0] op_a;
  logic [32:0] op_b;
  logic [65:0] prod_full;
  logic        unused_bits;

  // The 33-bit operands are sign-extended to 66 bits before the multiply, so an
  // unsigned multiply produces the correct two's-complement product bits.
  always_comb begin
    in_f3     = issue_data[86:84];
    op_a      = {((in_f3 == 3'b001) || (in_f3 == 3'b010)) & issue_data[83], issue_data[83:52]};
    op_b      = {(in_f3 == 3'b001) & issue_data[44], issue_data[44:13]};
    prod_full = {{33{op_a[32]}}, op_a} * {{33{op_b[32]}}, op_b};
    entry.vld    = issue_data[51] & issue_data[12];
    entry.tag    = issue_data[5:0];
    entry.funct3 = in_f3;
    entry.prod   = prod_full[63:0];
  end

  assign unused_bits = ^{issue_data[DATA_WIDTH-1:87], issue_data[50:45],
                         issue_data[11:6], prod_full[65:64]};

  always_comb begin
    tail        = stg_q[LATENCY-1];
    stall       = tail.vld & ~cdb_grant;
    o_rsv_rd_en = ~stall;
    cdb_req     = tail.vld;
    o_cdb_valid = tail.vld & cdb_grant & ~flush;
    o_cdb_tag   = tail.vld ? tail.tag : '0;
    o_cdb_data  = '0;
    if (tail.vld) begin
      case (tail.funct3)
        3'b000:                 o_cdb_data = tail.prod[31:0];
        3'b001, 3'b010, 3'b011: o_cdb_data = tail.prod[63:32];
        default:                o_cdb_data = '0;
      endcase
    end
    o_busy = 1'b0;
    for (int unsigned i = 0; i < LATENCY; i++) begin
      o_busy = o_busy | stg_q[i].vld;
    end
  end

  // The whole pipe advances or holds as a unit; bubbles are never squeezed out.
  always_comb begin
    for (int unsigned i = 0; i < LATENCY; i++) begin
      stg_d[i] = stg_q[i];
    end
    if (!stall) begin
      stg_d[0] = entry;
      for (int unsigned i = 1; i < LATENCY; i++) begin
        stg_d[i] = stg_q[i-1];
      end
    end
    if (flush) begin
      for (int unsigned i = 0; i < LATENCY; i++) begin
        stg_d[i].vld = 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned i = 0; i < LATENCY; i++) begin
        stg_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < LATENCY; i++) begin
        stg_q[i] <= stg_d[i];
      end
    end
  end

endmodule

// File: tb/tb_exec_mul_unit.sv
// Scoreboard bench for exec_mul_unit: a driver queues the expected results,
// and a monitor pops and compares them whenever the unit drives the CDB.
module tb_exec_mul_unit;
  localparam int unsigned LAT = 3;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         flush = 1'b0;
  logic         grant = 1'b0;
  logic [127:0] issue_data = '0;
  logic         rd_en, cdb_req, cdb_valid, busy;
  logic [5:0]   cdb_tag;
  logic [31:0]  cdb_data;

  exec_mul_unit #(.LATENCY(LAT), .DATA_WIDTH(128)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .flush(flush), .o_rsv_rd_en(rd_en),
    .issue_data(issue_data), .cdb_grant(grant), .cdb_req(cdb_req),
    .o_cdb_valid(cdb_valid), .o_cdb_tag(cdb_tag), .o_cdb_data(cdb_data), .o_busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct { logic [5:0] tag; logic [31:0] data; } exp_t;
  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  bit   rand_grant = 1'b0;
  int   g_lo = -1;
  int   g_hi = -2;
  bit   mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  initial forever begin
    @(posedge clk); #1;
    if (rand_grant) grant = ($urandom_range(0, 3) != 0);
    else            grant = !(cyc >= g_lo && cyc <= g_hi);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: full-precision products in 64-bit arithmetic, then the RV32M word select.
  function automatic logic [31:0] ref_mul(input logic [2:0] f3, input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa, sb_, ua, ub, p;
    sa  = $signed({{32{a[31]}}, a});
    sb_ = $signed({{32{b[31]}}, b});
    ua  = $signed({32'h0, a});
    ub  = $signed({32'h0, b});
    case (f3)
      3'd0: begin p = ua * ub;  return p[31:0];  end
      3'd1: begin p = sa * sb_; return p[63:32]; end
      3'd2: begin p = sa * ub;  return p[63:32]; end
      3'd3: begin p = ua * ub;  return p[63:32]; end
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [127:0] mk(input logic [2:0] f3, input logic [31:0] a,
                                      input logic [31:0] b, input logic [5:0] tag,
                                      input logic v1, input logic v2, input bit junk);
    logic [127:0] e;
    e = junk ? {$urandom, $urandom, $urandom, $urandom} : '0;
    e[86:84] = f3; e[83:52] = a; e[51] = v1; e[44:13] = b; e[12] = v2; e[5:0] = tag;
    return e;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return 32'h7FFFFFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Present an entry until the station handshake takes it; queue the expected result.
  task automatic send(input logic [127:0] e, input bit track, input logic [31:0] exp_d);
    exp_t x;
    issue_data = e;
    for (int n = 0; n < 64; n++) begin
      @(negedge clk);
      if (rd_en && !flush) begin
        if (track && e[51] && e[12]) begin
          x.tag = e[5:0]; x.data = exp_d; sb.push_back(x);
        end
        tick();
        issue_data = '0;
        return;
      end
      tick();
    end
    n_checks++; n_errors++;
    $display("FAIL issue_timeout: actual=not accepted required=accepted within 64 cycles");
    issue_data = '0;
  endtask

  task automatic wait_drain();
    for (int n = 0; n < 200; n++) begin
      if (sb.size() == 0 && !busy) break;
      @(negedge clk);
    end
    chk("drain_pending", sb.size(), 0);
    chk("drain_busy", busy, 0);
  endtask

  initial forever begin
    @(negedge clk);
    if (mon_en) begin
      chk("rd_en_rule", rd_en, !(cdb_req && !grant));
      chk("cdb_valid_rule", cdb_valid, cdb_req && grant && !flush);
      if (!cdb_req) begin
        chk("idle_tag", cdb_tag, 0);
        chk("idle_data", cdb_data, 0);
      end
      if (cdb_valid) begin
        if (sb.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL unexpected_result: actual tag=%0h data=%0h required=no result", cdb_tag, cdb_data);
        end else begin
          mon_e = sb.pop_front();
          chk("result_tag", cdb_tag, mon_e.tag);
          chk("result_data", cdb_data, mon_e.data);
        end
      end
    end
  end

  initial begin
    logic [2:0]  f3;
    logic [31:0] a, b;
    logic [5:0]  tg;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req", cdb_req, 0);   chk("rst_valid", cdb_valid, 0);
    chk("rst_tag", cdb_tag, 0);   chk("rst_data", cdb_data, 0);
    chk("rst_busy", busy, 0);     chk("rst_rd_en", rd_en, 1);
    rst_n = 1'b1; mon_en = 1'b1;
    tick();

    // T1: MUL 7 x -3, fixed latency
    fork
      send(mk(3'd0, 32'd7, 32'hFFFFFFFD, 6'h2A, 1, 1, 0), 1, 32'hFFFFFFEB);
      for (int k = 0; k < 6; k++) begin
        @(negedge clk);
        chk("t1_req", cdb_req, k == 3);
        if (k == 3) begin
          chk("t1_tag", cdb_tag, 6'h2A);
          chk("t1_data", cdb_data, 32'hFFFFFFEB);
        end
      end
    join
    tick();

    // T2: high-word variants and a reserved funct3
    send(mk(3'd1, 32'h80000000, 32'h80000000, 6'h01, 1, 1, 0), 1, 32'h40000000);
    send(mk(3'd3, 32'hFFFFFFFF, 32'd2, 6'h02, 1, 1, 0), 1, 32'h00000001);
    send(mk(3'd2, 32'hFFFFFFFF, 32'd2, 6'h03, 1, 1, 0), 1, 32'hFFFFFFFF);
    send(mk(3'd5, 32'h12345678, 32'h9, 6'h21, 1, 1, 0), 1, 32'h0);
    wait_drain();
    tick();

    // T3: grant withheld in relative cycles 3..5
    g_lo = cyc + 1 + 3; g_hi = cyc + 1 + 5;
    tick();
    fork
      for (int i = 0; i < 4; i++) begin
        f3 = 3'($urandom_range(0, 3)); a = pick(); b = pick();
        send(mk(f3, a, b, 6'(8 + i), 1, 1, 1), 1, ref_mul(f3, a, b));
      end
      for (int k = 0; k < 12; k++) begin
        @(negedge clk);
        chk("t3_rd_en", rd_en, !(k >= 3 && k <= 5));
        chk("t3_valid", cdb_valid, k >= 6 && k <= 9);
      end
    join
    g_lo = -1; g_hi = -2;
    wait_drain();
    tick();

    // T4: flush two in-flight ops, then a fresh issue
    fork
      begin
        send(mk(3'd0, 32'd3, 32'd4, 6'h10, 1, 1, 0), 0, 32'h0);
        send(mk(3'd0, 32'd5, 32'd6, 6'h11, 1, 1, 0), 0, 32'h0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        send(mk(3'd0, 32'd9, 32'd9, 6'h12, 1, 1, 0), 1, 32'd81);
      end
      for (int k = 0; k < 9; k++) begin
        @(negedge clk);
        if (k == 2) chk("t4_busy_before", busy, 1);
        if (k == 3) chk("t4_busy_after", busy, 0);
        chk("t4_valid", cdb_valid, k == 6);
      end
    join
    wait_drain();
    tick();

    // T4b: flush in the very cycle a granted result sits in the tail
    fork
      send(mk(3'd0, 32'd2, 32'd2, 6'h13, 1, 1, 0), 0, 32'h0);
      begin
        repeat (3) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
      end
      for (int k = 0; k < 5; k++) begin
        @(negedge clk);
        if (k == 3) begin
          chk("t4b_req", cdb_req, 1);
          chk("t4b_valid", cdb_valid, 0);
        end
        if (k == 4) chk("t4b_busy", busy, 0);
      end
    join
    tick();

    // T5: bubbles and half-valid entries never enter the pipe as work
    for (int i = 0; i < 9; i++) begin
      case (i % 3)
        0: issue_data = '0;
        1: issue_data = mk(3'd0, $urandom, $urandom, 6'h3F, 1, 0, 0);
        default: issue_data = mk(3'd1, $urandom, $urandom, 6'h3E, 0, 1, 0);
      endcase
      @(negedge clk);
      chk("t5_req", cdb_req, 0);
      chk("t5_busy", busy, 0);
      tick();
    end
    issue_data = '0;

    // T6: asynchronous reset with three ops in flight
    send(mk(3'd0, 32'd1, 32'd1, 6'h20, 1, 1, 0), 0, 32'h0);
    send(mk(3'd0, 32'd2, 32'd1, 6'h21, 1, 1, 0), 0, 32'h0);
    send(mk(3'd0, 32'd3, 32'd1, 6'h22, 1, 1, 0), 0, 32'h0);
    chk("t6_busy_before", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("t6_req", cdb_req, 0);   chk("t6_valid", cdb_valid, 0);
    chk("t6_tag", cdb_tag, 0);   chk("t6_data", cdb_data, 0);
    chk("t6_busy", busy, 0);     chk("t6_rd_en", rd_en, 1);
    repeat (2) tick();
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("t6_no_req", cdb_req, 0);
    end
    tick();

    // Random traffic with random grant
    rand_grant = 1'b1;
    for (int i = 0; i < 300; i++) begin
      f3 = 3'($urandom_range(0, 7)); a = pick(); b = pick(); tg = 6'($urandom);
      if ($urandom_range(0, 5) == 0)
        send(mk(f3, a, b, tg, 1'($urandom), 0, 1), 1, 32'h0);
      else
        send(mk(f3, a, b, tg, 1, 1, 1), 1, ref_mul(f3, a, b));
    end
    wait_drain();
    rand_grant = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
